// File: rtl/controlador_sequenciador.sv
// SAP-1 controller-sequencer: six-state T ring running fetch (T1..T3) and
// opcode-driven execute (T4..T6), plus a HALT sink left only through clr.
module controlador_sequenciador #(
  parameter logic [3:0] OPC_LDA = 4'b0000,
  parameter logic [3:0] OPC_ADD = 4'b0001,
  parameter logic [3:0] OPC_SUB = 4'b0010,
  parameter logic [3:0] OPC_OUT = 4'b1110,
  parameter logic [3:0] OPC_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] opcode,
  output logic [5:0] t,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (clr)
      state <= S_T1;
    else if (en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_T4;
      S_T4:    state_nxt = (opcode == OPC_HLT) ? S_HALT : S_T5;
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_T1;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T1;
    endcase
  end

  // Ring position and halt flag track the held state even while paused.
  always_comb begin
    t   = '0;
    hlt = 1'b0;
    unique case (state)
      S_T1:    t = 6'b000001;
      S_T2:    t = 6'b000010;
      S_T3:    t = 6'b000100;
      S_T4:    t = 6'b001000;
      S_T5:    t = 6'b010000;
      S_T6:    t = 6'b100000;
      S_HALT:  hlt = 1'b1;
      default: t = '0;
    endcase
  end

  // Controls are masked by en so a paused cycle never repeats a load or increment.
  always_comb begin
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
    li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
    su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
    if (en) begin
      unique case (state)
        S_T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        S_T2: cp = 1'b1;
        S_T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        S_T4: begin
          if (opcode == OPC_LDA || opcode == OPC_ADD || opcode == OPC_SUB) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (opcode == OPC_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        S_T5: begin
          if (opcode == OPC_LDA) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (opcode == OPC_ADD || opcode == OPC_SUB) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        S_T6: begin
          if (opcode == OPC_ADD || opcode == OPC_SUB) begin
            la = 1'b1;
            eu = 1'b1;
            su = (opcode == OPC_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Scoreboard bench for controlador_sequenciador: a bench-side state model
// pushes the expected output word each cycle, popped and compared at negedge.
module tb_controlador_sequenciador;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] t;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

  int checks = 0;
  int failures = 0;
  int mstate = 0;  // 0..5 = T1..T6, 6 = HALT
  logic [18:0] sb[$];
  logic [18:0] got, exp_v;

  always #5 clk = ~clk;

  controlador_sequenciador #(
    .OPC_LDA(4'b0000), .OPC_ADD(4'b0001), .OPC_SUB(4'b0010),
    .OPC_OUT(4'b1110), .OPC_HLT(4'b1111)
  ) dut (
    .clk(clk), .clr(clr), .en(en), .opcode(opcode), .t(t),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
    .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
  );

  // Word layout: {t[5:0], hlt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}
  function automatic logic [18:0] model_out(input int s, input logic [3:0] o, input logic e);
    logic [5:0] tt;
    logic h;
    logic [11:0] c;  // {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    tt = (s < 6) ? (6'b000001 << s) : 6'b000000;
    h = (s == 6);
    c = 12'b0;
    if (e) begin
      case (s)
        0: c = 12'b0110_0000_0000;
        1: c = 12'b1000_0000_0000;
        2: c = 12'b0001_1000_0000;
        3: if (o == 4'h0 || o == 4'h1 || o == 4'h2) c = 12'b0010_0100_0000;
           else if (o == 4'hE) c = 12'b0000_0001_0001;
        4: if (o == 4'h0) c = 12'b0001_0010_0000;
           else if (o == 4'h1 || o == 4'h2) c = 12'b0001_0000_0010;
        5: if (o == 4'h1) c = 12'b0000_0010_0100;
           else if (o == 4'h2) c = 12'b0000_0010_1100;
        default: c = 12'b0;
      endcase
    end
    return {tt, h, c};
  endfunction

  function automatic int model_next(input int s, input logic c, input logic e, input logic [3:0] o);
    if (c) return 0;
    if (!e) return s;
    if (s == 6) return 6;
    if (s == 3 && o == 4'hF) return 6;
    return (s + 1) % 6;
  endfunction

  task automatic drive(input logic c, input logic e, input logic [3:0] o);
    clr = c; en = e; opcode = o;
    sb.push_back(model_out(mstate, o, e));
    @(negedge clk);
    got = {t, hlt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
  endtask

  task automatic advance();
    @(posedge clk);
    mstate = model_next(mstate, clr, en, opcode);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b1, 4'h0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL reset_sb cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i == 1) begin
        checks++;
        if (t !== 6'b000001 || ep !== 1'b1 || lm !== 1'b1 || hlt !== 1'b0 || cp !== 1'b0) begin
          failures++;
          $display("FAIL reset_t1 got t=%b ep=%b lm=%b hlt=%b cp=%b exp t=000001 ep=1 lm=1 hlt=0 cp=0", t, ep, lm, hlt, cp);
        end
      end
      if (i == 2) begin
        checks++;
        if (t !== 6'b000010 || cp !== 1'b1 || {ep, lm, ce, li} !== 4'b0) begin
          failures++;
          $display("FAIL reset_t2 got t=%b cp=%b exp t=000010 cp=1 only", t, cp);
        end
      end
      if (i == 3) begin
        checks++;
        if (t !== 6'b000100 || ce !== 1'b1 || li !== 1'b1 || cp !== 1'b0) begin
          failures++;
          $display("FAIL reset_t3 got t=%b ce=%b li=%b exp t=000100 ce=1 li=1", t, ce, li);
        end
      end
      advance();
    end
  endtask

  // Runs one instruction from a fresh reset: reset cycle + T1..T6 + wrap T1.
  task automatic test_instr(input logic [3:0] o, input string name);
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, o);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, got, exp_v);
      end
      if (i == 6 && o == 4'h2) begin
        checks++;
        if ({la, eu, su} !== 3'b111) begin
          failures++;
          $display("FAIL sub_t6 got la,eu,su=%b exp 111", {la, eu, su});
        end
      end
      if (i == 6 && o == 4'h1) begin
        checks++;
        if ({la, eu, su} !== 3'b110) begin
          failures++;
          $display("FAIL add_t6 got la,eu,su=%b exp 110", {la, eu, su});
        end
      end
      if (i == 7) begin
        checks++;
        if (t !== 6'b000001) begin
          failures++;
          $display("FAIL %s_wrap got t=%b exp 000001", name, t);
        end
      end
      advance();
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 17; i++) begin
      drive(i == 0 || i == 15, (i < 5) ? 1'b1 : logic'(i % 2), 4'hF);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i >= 5 && i <= 15) begin
        checks++;
        if (t !== 6'b0 || hlt !== 1'b1 || {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} !== 12'b0) begin
          failures++;
          $display("FAIL halt_hold cyc=%0d got t=%b hlt=%b exp t=000000 hlt=1 controls 0", i, t, hlt);
        end
      end
      if (i == 16) begin
        checks++;
        if (t !== 6'b000001 || hlt !== 1'b0) begin
          failures++;
          $display("FAIL halt_clr got t=%b hlt=%b exp t=000001 hlt=0", t, hlt);
        end
      end
      advance();
    end
  endtask

  task automatic test_pause();
    int cp_cnt;
    cp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, !(i >= 2 && i <= 4), 4'h0);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (cp === 1'b1) cp_cnt++;
      if (i >= 2 && i <= 4) begin
        checks++;
        if (t !== 6'b000010 || cp !== 1'b0) begin
          failures++;
          $display("FAIL pause_hold cyc=%0d got t=%b cp=%b exp t=000010 cp=0", i, t, cp);
        end
      end
      advance();
    end
    checks++;
    if (cp_cnt != 1) begin
      failures++;
      $display("FAIL pause_cp_count got %0d exp 1", cp_cnt);
    end
    checks++;
    if (t !== 6'b001000) begin
      failures++;
      $display("FAIL pause_resume got t=%b exp 001000", t);
    end
  endtask

  // clr lands at the edge ending T5; the restarted fetch must not load B.
  task automatic test_clr_mid();
    for (int i = 0; i < 10; i++) begin
      drive(i == 0 || i == 5, 1'b1, 4'h1);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL clr_mid cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i == 6) begin
        checks++;
        if (t !== 6'b000001) begin
          failures++;
          $display("FAIL clr_mid_t1 got t=%b exp 000001", t);
        end
      end
      if (i >= 6) begin
        checks++;
        if (lb !== 1'b0) begin
          failures++;
          $display("FAIL clr_mid_lb cyc=%0d got lb=%b exp 0", i, lb);
        end
      end
      advance();
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, 1'b1, 4'h5);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL nop cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (i >= 4) begin
        checks++;
        if ({cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} !== 12'b0) begin
          failures++;
          $display("FAIL nop_ctrl cyc=%0d got=%b exp 000000000000", i,
                   {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo});
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [3:0] ops[6];
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h7};
    for (int i = 0; i < 300; i++) begin
      drive(i == 0 || $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
            ops[$urandom_range(0, 5)]);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, got, exp_v);
      end
      checks++;
      if (int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu) > 1) begin
        failures++;
        $display("FAIL bus_conflict cyc=%0d got ep,ce,ei,ea,eu=%b exp at most one", i,
                 {ep, ce, ei, ea, eu});
      end
      advance();
    end
  endtask

  initial begin
    clr = 1'b1; en = 1'b1; opcode = 4'h0;
    @(posedge clk);
    mstate = 0;
    #1;
    test_reset();
    test_instr(4'h0, "lda");
    test_instr(4'h2, "sub");
    test_instr(4'h1, "add");
    test_instr(4'hE, "out");
    test_halt();
    test_pause();
    test_clr_mid();
    test_nop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_sequenciador.md
Name: controlador_sequenciador

Overview:
SAP-1 controller-sequencer: the consumer of the instruction register's opcode nibble and the driver of its load/enable controls.
- Six-state ring (T1..T6) runs the fetch cycle, then decodes the opcode during T4..T6 into the 12-bit control word plus halt.
- li drives the IR load input, ei drives the IR ei_lsb input, and opcode comes from IR output bits [7:4].
- All control outputs are active-high.

Parameters:
OPC_LDA, 4'b0000, opcode for load accumulator from memory
OPC_ADD, 4'b0001, opcode for A = A + B(mem)
OPC_SUB, 4'b0010, opcode for A = A - B(mem)
OPC_OUT, 4'b1110, opcode for accumulator to output register
OPC_HLT, 4'b1111, opcode for halt

Ports:
clk  in  1  system clock; all state changes on its rising edge
clr  in  1  reset, synchronous, active-high
en  in  1  run enable (0 = single-step pause)
opcode  in  4  IR upper nibble; sampled only in T4..T6
t  out  6  one-hot ring state, bit0 = T1 .. bit5 = T6; 0 when halted
cp  out  1  PC increment
ep  out  1  PC onto bus
lm  out  1  load MAR
ce  out  1  RAM onto bus
li  out  1  load IR (to IR load)
ei  out  1  IR low nibble onto bus (to IR ei_lsb)
la  out  1  load accumulator
ea  out  1  accumulator onto bus
su  out  1  ALU subtract select
eu  out  1  ALU onto bus
lb  out  1  load B register
lo  out  1  load output register
hlt  out  1  halted flag

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high.
- State register: T1..T6 plus HALT.
- Reset: clr=1 at a rising edge forces T1 and overrides en and all other inputs, from any state including HALT or mid-instruction.
  - After reset: t=6'b000001, hlt=0.
  - Control outputs then follow the T1 decode (ep=1, lm=1) if en=1, else all 0.
- Advance: when en=1, T1->T2->T3->T4->T5->T6->T1, one state per edge.
  - Exception: from T4 with opcode==OPC_HLT, next state is HALT.
- en=0: state holds, and all 12 control outputs are forced 0 that cycle, so no double increment or load. t and hlt still reflect the held state.
- HALT: t=0, hlt=1, all controls 0. Stays in HALT regardless of en/opcode until clr.
- Control outputs are combinational from (state, opcode, en), with no added latency.
  - Each asserted signal takes effect at the rising edge that ends its state.
- Decode, listing only the asserted signals; all others are 0:
  - T1: ep, lm (any opcode)
  - T2: cp
  - T3: ce, li (IR captures the instruction at the end of T3)
  - T4: LDA/ADD/SUB: ei, lm. OUT: ea, lo. HLT: none. Other opcode: none.
  - T5: LDA: ce, la. ADD/SUB: ce, lb. Others: none.
  - T6: ADD: la, eu. SUB: la, eu, su. Others: none.
- Undefined opcodes (0011..1101) run as NOP: a full 6-cycle instruction with only the fetch signals.
- opcode changes during T1..T3 have no effect on outputs.
- Invariant: at most one bus driver (ep, ce, ei, ea, eu) is high in any cycle.
- Program length is unbounded; the ring wraps T6->T1 indefinitely.

Test Plan:
- clr=1 one edge, en=1, opcode=0000 -> t=000001, ep=lm=1, hlt=0. Next edges: t=000010 with cp=1 only, then t=000100 with ce=li=1.
- en=1, opcode=0000 (LDA) across T4..T6 -> T4 ei=lm=1; T5 ce=la=1; T6 all controls 0; next edge t=000001.
- opcode=0010 (SUB) -> T5 ce=lb=1; T6 la=eu=su=1. opcode=0001 (ADD) -> T6 la=eu=1, su=0.
- opcode=1111 reaching T4 -> next edge t=0, hlt=1, controls 0. Holds 10 cycles with en toggling. clr=1 -> t=000001, hlt=0.
- In T2, drop en for 3 cycles -> t stays 000010, cp=0 throughout. Raise en -> cp=1 for exactly one cycle, then T3.
- clr=1 while in T5 with opcode=0001 -> next edge t=000001, lb never asserted. opcode=0101 -> T4..T6 all controls 0.
